dmem_port_arbiter: RTL

//  Shares the single-port data RAM of Gambling_Tec between three masters: the CPU

---
 rtl/gambling_mem_pkg.sv | 23 ++
 rtl/dmem_port_arbiter_rr_pick2.sv | 30 +++
 rtl/dmem_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gambling_mem_pkg.sv
// Shared data-RAM map and slot-owner encoding for the Gambling_Tec memory arbiter.
package gambling_mem_pkg;

  localparam int KEY_ADDR    = 10;
  localparam int MONEY_ADDR  = 20;
  localparam int SYM_A_ADDR  = 24;
  localparam int SYM_B_ADDR  = 28;
  localparam int SYM_C_ADDR  = 32;
  localparam int RESULT_ADDR = 36;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_CPU  = 3'd1,
    OWN_KBD  = 3'd2,
    OWN_VID  = 3'd3,
    OWN_CLR  = 3'd4
  } owner_e;

  // Round-robin pointer encoding: which peripheral wins a tie.
  localparam logic RR_KBD = 1'b0;
  localparam logic RR_VID = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: req[0]=keyboard, req[1]=video; ptr selects the tie winner.
module rr_pick2
  import gambling_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_nxt_o
);

  always_comb begin
    gnt_o     = 2'b00;
    ptr_nxt_o = ptr_i;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (ptr_i == RR_VID) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    // After a grant the other requester gets the next tie.
    if (gnt_o[0]) begin
      ptr_nxt_o = RR_VID;
    end else if (gnt_o[1]) begin
      ptr_nxt_o = RR_KBD;
    end else begin
      ptr_nxt_o = ptr_i;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data RAM arbiter: CPU first, keyboard/video round-robin with starvation guard.
// Optional DMEM_ARB_KEY_AUTOCLEAR_EN: CPU read of KEY_ADDR schedules a zero write to it.
module dmem_port_arbiter
  import gambling_mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int KEY_ADDR     = gambling_mem_pkg::KEY_ADDR,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          kbd_req,
  input  logic [7:0]    kbd_code,
  output logic          kbd_gnt,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);

  logic [WCW-1:0] wait_q, wait_d;
  logic           rr_q, rr_d;
  logic           vid_valid_q, vid_valid_d;
  logic [DW-1:0]  vid_rdata_q, vid_rdata_d;
  logic           clr_pend_q, clr_pend_d;

  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic       ptr_nxt_s;
  logic       periph_req_s;
  logic       periph_gnt_s;
  logic       forced_s;
  owner_e     owner_s;

  assign req_s        = {vid_req, kbd_req};
  assign periph_req_s = |req_s;
  assign forced_s     = periph_req_s && (wait_q == WAIT_MAX);

  rr_pick2 u_rr (
    .req_i     (req_s),
    .ptr_i     (rr_q),
    .gnt_o     (gnt_s),
    .ptr_nxt_o (ptr_nxt_s)
  );

  // Slot ownership; nothing is driven to the RAM while reset is held.
  always_comb begin
    owner_s   = OWN_NONE;
    cpu_stall = 1'b0;
    if (rst) begin
      owner_s = OWN_NONE;
    end else if (forced_s) begin
      owner_s   = gnt_s[0] ? OWN_KBD : OWN_VID;
      cpu_stall = 1'b1;
    end else if (cpu_en) begin
      owner_s = OWN_CPU;
    end else if (periph_req_s) begin
      owner_s = gnt_s[0] ? OWN_KBD : OWN_VID;
    end else if (clr_pend_q) begin
      owner_s = OWN_CLR;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner_s)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_KBD: begin
        mem_we    = 1'b1;
        mem_addr  = AW'(KEY_ADDR);
        mem_wdata = DW'(kbd_code);
      end
      OWN_VID: begin
        mem_we    = 1'b0;
        mem_addr  = vid_addr;
      end
      OWN_CLR: begin
        mem_we    = 1'b1;
        mem_addr  = AW'(KEY_ADDR);
        mem_wdata = '0;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  assign cpu_rdata    = mem_rdata;
  assign kbd_gnt      = (owner_s == OWN_KBD);
  assign periph_gnt_s = (owner_s == OWN_KBD) || (owner_s == OWN_VID);
  assign vid_valid    = vid_valid_q;
  assign vid_rdata    = vid_rdata_q;

  always_comb begin
    wait_d      = wait_q;
    rr_d        = periph_gnt_s ? ptr_nxt_s : rr_q;
    vid_valid_d = (owner_s == OWN_VID);
    vid_rdata_d = (owner_s == OWN_VID) ? mem_rdata : vid_rdata_q;
    if (periph_gnt_s || !periph_req_s) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WCW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

`ifdef DMEM_ARB_KEY_AUTOCLEAR_EN
  // A fresh key write always wins over a pending clear so no scancode is lost.
  always_comb begin
    clr_pend_d = clr_pend_q;
    if (owner_s == OWN_KBD || owner_s == OWN_CLR) begin
      clr_pend_d = 1'b0;
    end else if (owner_s == OWN_CPU && !cpu_we && cpu_addr == AW'(KEY_ADDR)) begin
      clr_pend_d = 1'b1;
    end else begin
      clr_pend_d = clr_pend_q;
    end
  end
`else
  assign clr_pend_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q      <= '0;
      rr_q        <= RR_KBD;
      vid_valid_q <= 1'b0;
      vid_rdata_q <= '0;
      clr_pend_q  <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      rr_q        <= rr_d;
      vid_valid_q <= vid_valid_d;
      vid_rdata_q <= vid_rdata_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

endmodule
